hazard_ctrl: RTL

Hazard control unit that produces the `stall`, `flush` and `cycle_count` signals consumed by the decode/execute pipeline register and by fetch. It compares the decode-stage source registers against the instruction in execute and holds the front end for a fixed number of cycles on a data hazard. It asserts a flush on a taken branch and masks further hazard detection while the squash window drains. It sits between the decode and execute stages of the RV32 core.

---
 rtl/hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard control for the decode/execute boundary of the RV32 core. It compares
// the decode-stage source registers against the destination of the instruction
// in EX. On a data hazard it holds the front end for STALL_CYCLES cycles, plus
// one extra cycle for every cycle mem_wait is high at the exit point. On a
// taken branch it raises a one-cycle flush and then masks hazard and branch
// detection until the FLUSH_CYCLES squash window has drained.
//
// Outputs are Mealy: they respond to the current inputs within the same cycle.
//
// Build option:
//   HAZARD_FWD_EN  defined   -> a forwarding network exists, so only load-use
//                               dependencies (mem_read_ex) stall.
//                  undefined -> any RAW dependency on the EX instruction stalls.
//
// Parameters:
//   STALL_CYCLES  hazard stall length in cycles, 1..7 (default 2)
//   FLUSH_CYCLES  squash window length including the flush cycle, 1..7 (default 3)
//
// Ports:
//   clk              in   core clock
//   reset            in   asynchronous, active-low reset
//   instr_valid_dec  in   decode holds a real instruction
//   rs1_dec/rs2_dec  in   decode source registers [4:0]
//   uses_rs1_dec     in   decode instruction reads rs1
//   uses_rs2_dec     in   decode instruction reads rs2
//   write_reg_ex     in   destination register of the EX instruction [4:0]
//   reg_write_ex     in   EX instruction writes the register file
//   mem_read_ex      in   EX instruction is a load
//   branch_taken_ex  in   EX resolved a taken branch or jump
//   mem_wait         in   data memory not ready; extends an active stall
//   stall            out  hold PC and IF/DEC; DEC/EX injects a bubble
//   cycle_count      out  0-based index of the current stall cycle [2:0]
//   flush            out  single-cycle squash request
//   flush_active     out  high for the whole squash window
// -----------------------------------------------------------------------------

module hazard_ctrl #(
    parameter int STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid_dec,
    input  logic [4:0] rs1_dec,
    input  logic [4:0] rs2_dec,
    input  logic       uses_rs1_dec,
    input  logic       uses_rs2_dec,
    input  logic [4:0] write_reg_ex,
    input  logic       reg_write_ex,
    input  logic       mem_read_ex,
    input  logic       branch_taken_ex,
    input  logic       mem_wait,
    output logic       stall,
    output logic [2:0] cycle_count,
    output logic       flush,
    output logic       flush_active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Last counter value of a stall / squash window.
    localparam logic [2:0] STALL_LAST = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    // A decode operand depends on EX only if it is actually read and names
    // the EX destination.
    function automatic logic src_match(
        input logic       uses,
        input logic [4:0] src,
        input logic [4:0] dst
    );
        return uses && (src == dst);
    endfunction

    // Counter that saturates at its maximum so long memory waits cannot wrap
    // cycle_count back to zero.
    function automatic logic [2:0] sat_inc(input logic [2:0] value);
        return (value == 3'd7) ? 3'd7 : value + 3'd1;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;

    logic       dep_qual_s;
    logic       haz_s;

    logic       stall_s;
    logic [2:0] cycle_count_s;
    logic       flush_s;
    logic       flush_active_s;

`ifdef HAZARD_FWD_EN
    // Forwarding covers ALU results; only a load still in EX forces a stall.
    assign dep_qual_s = mem_read_ex;
`else
    // Without forwarding every RAW dependency on EX stalls; the load flag is
    // not needed in this build.
    logic unused_mem_read_s;
    assign unused_mem_read_s = mem_read_ex;
    assign dep_qual_s        = 1'b1;
`endif

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    assign haz_s = instr_valid_dec
                 & reg_write_ex
                 & (write_reg_ex != 5'd0)
                 & (src_match(uses_rs1_dec, rs1_dec, write_reg_ex)
                  | src_match(uses_rs2_dec, rs2_dec, write_reg_ex))
                 & dep_qual_s;

    // State and shared stall/flush counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic and pre-reset Mealy outputs.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        stall_s        = 1'b0;
        cycle_count_s  = 3'd0;
        flush_s        = 1'b0;
        flush_active_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (branch_taken_ex) begin
                    // Branch wins over a simultaneous hazard.
                    flush_s        = 1'b1;
                    flush_active_s = 1'b1;
                    if (FLUSH_CYCLES == 1) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 3'd0;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = 3'd1;
                    end
                end else if (haz_s) begin
                    stall_s       = 1'b1;
                    cycle_count_s = 3'd0;
                    if ((STALL_CYCLES == 1) && !mem_wait) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 3'd0;
                    end else begin
                        state_nxt_s = ST_STALL;
                        cnt_nxt_s   = 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                end
            end

            ST_STALL: begin
                if (branch_taken_ex) begin
                    // A taken branch abandons the stall; the stalled decode
                    // instruction is on the wrong path anyway.
                    flush_s        = 1'b1;
                    flush_active_s = 1'b1;
                    if (FLUSH_CYCLES == 1) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 3'd0;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = 3'd1;
                    end
                end else begin
                    // haz is not consulted: EX holds the bubble we injected.
                    stall_s       = 1'b1;
                    cycle_count_s = cnt_r;
                    if ((cnt_r >= STALL_LAST) && !mem_wait) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 3'd0;
                    end else begin
                        state_nxt_s = ST_STALL;
                        cnt_nxt_s   = sat_inc(cnt_r);
                    end
                end
            end

            ST_FLUSH: begin
                // Decode contents are being squashed: hazards and branches
                // seen here are not real.
                flush_active_s = 1'b1;
                if (cnt_r >= FLUSH_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = sat_inc(cnt_r);
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, even though the inputs may
    // still present a hazard or branch.
    always_comb begin
        if (!reset) begin
            stall        = 1'b0;
            cycle_count  = 3'd0;
            flush        = 1'b0;
            flush_active = 1'b0;
        end else begin
            stall        = stall_s;
            cycle_count  = cycle_count_s;
            flush        = flush_s;
            flush_active = flush_active_s;
        end
    end

    hazard_ctrl_checker #(
        .STALL_CYCLES (STALL_CYCLES),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_checker (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .cycle_count  (cycle_count),
        .flush        (flush),
        .flush_active (flush_active)
    );

endmodule

// -----------------------------------------------------------------------------
// hazard_ctrl_checker
//
// Output invariants of hazard_ctrl. Pure observer; drives nothing.
//
// Ports:
//   clk, reset     clock and asynchronous active-low reset of the observed block
//   stall, cycle_count, flush, flush_active   observed outputs
// -----------------------------------------------------------------------------
module hazard_ctrl_checker #(
    parameter int STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES = 3
) (
    input logic       clk,
    input logic       reset,
    input logic       stall,
    input logic [2:0] cycle_count,
    input logic       flush,
    input logic       flush_active
);

    a_stall_range: assert property (@(posedge clk)
        (STALL_CYCLES >= 1) && (STALL_CYCLES <= 7));

    a_flush_range: assert property (@(posedge clk)
        (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 7));

    a_stall_flush_excl: assert property (@(posedge clk) disable iff (!reset)
        !(stall && flush));

    a_flush_in_window: assert property (@(posedge clk) disable iff (!reset)
        flush |-> flush_active);

    a_count_only_in_stall: assert property (@(posedge clk) disable iff (!reset)
        !stall |-> (cycle_count == 3'd0));

endmodule
